// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode pipeline stage.
// Decodes one 16-bit instruction per cycle into the execute-stage control
// bundle, register indices and an extended immediate. The result sits in a
// single pipeline register behind a valid/ready handshake. A two-state
// machine tracks HALT, illegal opcodes are flagged, and accepted
// instructions are counted with saturation.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_instr    fetch side request and instruction word
//   in_ready             stage can accept (combinational)
//   flush                discard the held entry (branch redirect)
//   out_valid/out_ready  execute side handshake
//   regdst..regsrc       datapath control bundle
//   halt, illegal        bundle is HALT / opcode unimplemented
//   rs, rd, imm          register fields and extended immediate
//   halted               core halted (left only by rst)
//   dec_count            saturating count of accepted instructions
module decode_stage #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [15:0]       in_instr,
   output logic              in_ready,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        regdst,
   output logic              zext,
   output logic              regwrt,
   output logic [1:0]        bsource,
   output logic              branch,
   output logic              alujmp,
   output logic              asource,
   output logic [2:0]        aluop,
   output logic              inva,
   output logic              invb,
   output logic              memwrt,
   output logic              immsrc,
   output logic              regsrc,
   output logic              halt,
   output logic              illegal,
   output logic [2:0]        rs,
   output logic [2:0]        rd,
   output logic [DATA_W-1:0] imm,
   output logic              halted,
   output logic [CNT_W-1:0]  dec_count
);

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t state_r, state_s;

   logic              out_valid_r;
   logic [1:0]        regdst_r, regdst_s;
   logic              zext_r, zext_s;
   logic              regwrt_r, regwrt_s;
   logic [1:0]        bsource_r, bsource_s;
   logic [2:0]        aluop_r, aluop_s;
   logic              inva_r, inva_s;
   logic              invb_r, invb_s;
   logic              memwrt_r, memwrt_s;
   logic              immsrc_r, immsrc_s;
   logic              halt_r, halt_s;
   logic              illegal_r, illegal_s;
   logic [2:0]        rs_r, rd_r;
   logic [DATA_W-1:0] imm_r, imm_s;
   logic [CNT_W-1:0]  dec_count_r;

   logic [4:0] opcode_s;
   logic [4:0] imm5_s;
   logic       halted_s;
   logic       accept_s;
   logic       consume_s;

   assign opcode_s  = in_instr[15:11];
   assign imm5_s    = in_instr[4:0];
   assign halted_s  = (state_r == ST_HALTED);
   assign consume_s = out_valid_r && out_ready;
   // A held HALT blocks intake so nothing follows it into execute.
   assign in_ready  = !rst && !halted_s && !flush && !(out_valid_r && halt_r)
                      && (!out_valid_r || out_ready);
   assign accept_s  = in_valid && in_ready;

   // Combinational opcode decode into the next control bundle.
   always_comb begin
      regdst_s  = 2'b00;
      zext_s    = 1'b0;
      regwrt_s  = 1'b0;
      bsource_s = 2'b00;
      aluop_s   = 3'b000;
      inva_s    = 1'b0;
      invb_s    = 1'b0;
      memwrt_s  = 1'b0;
      immsrc_s  = 1'b0;
      halt_s    = 1'b0;
      illegal_s = 1'b0;
      case (opcode_s)
         5'b00000: halt_s = 1'b1;
         5'b00001: halt_s = 1'b0;
         5'b01000, 5'b01001: begin
            regdst_s  = 2'b01;
            bsource_s = 2'b01;
            regwrt_s  = 1'b1;
            aluop_s   = 3'b100;
            inva_s    = opcode_s[0];   // SUBI computes imm - Rs via ~Rs
         end
         5'b01010: begin
            regdst_s  = 2'b01;
            bsource_s = 2'b01;
            regwrt_s  = 1'b1;
            zext_s    = 1'b1;
            aluop_s   = 3'b111;
         end
         5'b01011: begin
            regdst_s  = 2'b01;
            bsource_s = 2'b01;
            regwrt_s  = 1'b1;
            zext_s    = 1'b1;
            invb_s    = 1'b1;
            aluop_s   = 3'b101;
         end
         5'b10000: begin
            bsource_s = 2'b01;
            memwrt_s  = 1'b1;
            immsrc_s  = 1'b1;
            aluop_s   = 3'b100;
         end
         5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
            regdst_s  = 2'b01;
            bsource_s = 2'b01;
            regwrt_s  = 1'b1;
            aluop_s   = {1'b0, opcode_s[1:0]};   // low opcode bits map to rol/sll/ror/srl
         end
         default: illegal_s = 1'b1;
      endcase
      imm_s = zext_s ? {{(DATA_W-5){1'b0}}, imm5_s}
                     : {{(DATA_W-5){imm5_s[4]}}, imm5_s};
   end

   // Halt state machine next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_RUN: begin
            if (consume_s && halt_r) begin
               state_s = ST_HALTED;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_HALTED: state_s = ST_HALTED;
         default:   state_s = ST_RUN;
      endcase
   end

   // Halt state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= state_s;
      end
   end

   // Pipeline register: reset > flush > accept/consume.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         regdst_r    <= 2'b00;
         zext_r      <= 1'b0;
         regwrt_r    <= 1'b0;
         bsource_r   <= 2'b00;
         aluop_r     <= 3'b000;
         inva_r      <= 1'b0;
         invb_r      <= 1'b0;
         memwrt_r    <= 1'b0;
         immsrc_r    <= 1'b0;
         halt_r      <= 1'b0;
         illegal_r   <= 1'b0;
         rs_r        <= 3'b000;
         rd_r        <= 3'b000;
         imm_r       <= '0;
      end else if (flush && !halted_s) begin
         out_valid_r <= 1'b0;
      end else if (accept_s) begin
         out_valid_r <= 1'b1;
         regdst_r    <= regdst_s;
         zext_r      <= zext_s;
         regwrt_r    <= regwrt_s;
         bsource_r   <= bsource_s;
         aluop_r     <= aluop_s;
         inva_r      <= inva_s;
         invb_r      <= invb_s;
         memwrt_r    <= memwrt_s;
         immsrc_r    <= immsrc_s;
         halt_r      <= halt_s;
         illegal_r   <= illegal_s;
         rs_r        <= in_instr[10:8];
         rd_r        <= in_instr[7:5];
         imm_r       <= imm_s;
      end else if (consume_s) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   // Saturating count of accepted instructions.
   always_ff @(posedge clk) begin
      if (rst) begin
         dec_count_r <= '0;
      end else if (accept_s && (dec_count_r != CNT_MAX)) begin
         dec_count_r <= dec_count_r + CNT_ONE;
      end else begin
         dec_count_r <= dec_count_r;
      end
   end

   assign out_valid = out_valid_r;
   assign regdst    = regdst_r;
   assign zext      = zext_r;
   assign regwrt    = regwrt_r;
   assign bsource   = bsource_r;
   assign branch    = 1'b0;
   assign alujmp    = 1'b0;
   assign asource   = 1'b0;
   assign aluop     = aluop_r;
   assign inva      = inva_r;
   assign invb      = invb_r;
   assign memwrt    = memwrt_r;
   assign immsrc    = immsrc_r;
   assign regsrc    = 1'b0;
   assign halt      = halt_r;
   assign illegal   = illegal_r;
   assign rs        = rs_r;
   assign rd        = rd_r;
   assign imm       = imm_r;
   assign halted    = halted_s;
   assign dec_count = dec_count_r;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage (CNT_W=4 so saturation is reachable).
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst, in_valid, flush, out_ready;
   logic [15:0] in_instr;
   logic        in_ready, out_valid;
   logic [1:0]  regdst, bsource;
   logic        zext, regwrt, branch, alujmp, asource;
   logic [2:0]  aluop, rs, rd;
   logic        inva, invb, memwrt, immsrc, regsrc, halt, illegal, halted;
   logic [15:0] imm;
   logic [3:0]  dec_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   decode_stage #(.DATA_W(16), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
      .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .regdst(regdst), .zext(zext), .regwrt(regwrt),
      .bsource(bsource), .branch(branch), .alujmp(alujmp), .asource(asource),
      .aluop(aluop), .inva(inva), .invb(invb), .memwrt(memwrt),
      .immsrc(immsrc), .regsrc(regsrc), .halt(halt), .illegal(illegal),
      .rs(rs), .rd(rd), .imm(imm), .halted(halted), .dec_count(dec_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0000; flush = 1'b0; out_ready = 1'b0;
      step();
      in_valid = 1'b1;
      #1 chk("in_ready_in_rst", in_ready, 0);
      step();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_dec_count", dec_count, 0);
      chk("rst_aluop", aluop, 0);
      chk("rst_imm", imm, 0);

      // Single ADDI
      in_valid = 1'b1; in_instr = 16'h4125; out_ready = 1'b1;
      #1 chk("addi_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("addi_valid", out_valid, 1);
      chk("addi_regdst", regdst, 2'b01);
      chk("addi_bsource", bsource, 2'b01);
      chk("addi_regwrt", regwrt, 1);
      chk("addi_aluop", aluop, 3'b100);
      chk("addi_imm", imm, 16'h0005);
      chk("addi_rs", rs, 1);
      chk("addi_rd", rd, 1);
      chk("addi_zext", zext, 0);
      chk("addi_count", dec_count, 1);
      step();
      chk("consume_clears_valid", out_valid, 0);

      // Extension: XORI 0x1F then ADDI 0x1F back to back
      in_valid = 1'b1; in_instr = 16'h501F;
      step();
      chk("xori_zext", zext, 1);
      chk("xori_imm", imm, 16'h001F);
      chk("xori_aluop", aluop, 3'b111);
      in_instr = 16'h401F;
      step();
      chk("addi_sext_imm", imm, 16'hFFFF);
      chk("addi_sext_zext", zext, 0);
      chk("ext_count", dec_count, 3);
      in_valid = 1'b0;
      step();
      chk("ext_drain", out_valid, 0);

      // Back-pressure: ADDI, SUBI, ST with out_ready low for 3 cycles
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h4125;
      step();
      in_instr = 16'h4925;
      for (int i = 0; i < 3; i++) begin
         chk("bp_in_ready", in_ready, 0);
         chk("bp_valid", out_valid, 1);
         chk("bp_inva_hold", inva, 0);
         chk("bp_count", dec_count, 4);
         step();
      end
      out_ready = 1'b1;
      #1 chk("bp_release_ready", in_ready, 1);
      step();
      chk("subi_inva", inva, 1);
      chk("subi_aluop", aluop, 3'b100);
      chk("subi_count", dec_count, 5);
      in_instr = 16'h8125;
      step();
      chk("st_memwrt", memwrt, 1);
      chk("st_immsrc", immsrc, 1);
      chk("st_regwrt", regwrt, 0);
      chk("st_regdst", regdst, 2'b00);
      chk("st_bsource", bsource, 2'b01);
      chk("st_count", dec_count, 6);

      // SRLI then illegal opcode 11000
      in_instr = 16'hB803;
      step();
      chk("srli_aluop", aluop, 3'b011);
      chk("srli_regdst", regdst, 2'b01);
      chk("srli_imm", imm, 16'h0003);
      in_instr = 16'hC0FF;
      step();
      chk("ill_flag", illegal, 1);
      chk("ill_regwrt", regwrt, 0);
      chk("ill_aluop", aluop, 0);
      chk("ill_bsource", bsource, 0);
      chk("ill_valid", out_valid, 1);
      chk("ill_rd", rd, 7);
      chk("ill_imm", imm, 16'hFFFF);
      chk("ill_count", dec_count, 8);
      in_valid = 1'b0;
      step();

      // Flush cancels a held HALT
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h0000;
      step();
      chk("hheld_halt", halt, 1);
      chk("hheld_ready", in_ready, 0);
      in_valid = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_valid", out_valid, 0);
      chk("flush_halted", halted, 0);
      chk("flush_count", dec_count, 9);

      // Halt: HALT then NOP with out_ready high
      out_ready = 1'b1; in_valid = 1'b1; in_instr = 16'h0000;
      step();
      in_instr = 16'h0800;
      #1 chk("halt_blocks_ready", in_ready, 0);
      step();
      chk("halted_set", halted, 1);
      chk("halted_valid", out_valid, 0);
      chk("nop_not_accepted", dec_count, 10);
      chk("halted_ready", in_ready, 0);
      flush = 1'b1;
      step();
      step();
      flush = 1'b0;
      chk("halted_sticky", halted, 1);
      chk("halted_count", dec_count, 10);
      chk("halted_valid2", out_valid, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_unhalt", halted, 0);
      chk("rst_count2", dec_count, 0);

      // Saturation: 20 NOPs
      in_instr = 16'h0800;
      for (int i = 0; i < 20; i++) begin
         step();
      end
      in_valid = 1'b0;
      chk("sat_count", dec_count, 15);
      chk("nop_regwrt", regwrt, 0);
      chk("nop_halt", halt, 0);
      chk("nop_illegal", illegal, 0);
      step();
      chk("sat_hold", dec_count, 15);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
